// File: rtl/alu_pkg.sv
// Shared ALU opcode enumeration used by the multicycle controller and the datapath.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_COPY_B
  } alu_op_t;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request handshake between the multicycle controller and memory.
//   mem_req   : controller requests a transfer (held until mem_ready)
//   mem_we    : 1 = store, 0 = load/fetch
//   addr_sel  : 0 = pc, 1 = alu_out
//   mem_ready : memory completes the transfer this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, mem_we, addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. Sequences FETCH / DECODE / EXECUTE / MEM /
// writeback for the instruction held in IR, steering the ALU and datapath
// muxes and resolving branches from the ALU flags of the EXECUTE cycle.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   instr           : current IR contents
//   mem             : memory request handshake (master side)
//   zero, lt, ltu   : ALU flags for the current cycle
//   alu_op, src_a_sel, src_b_sel : ALU operation and operand selects
//   ir_write, pc_write, pc_src   : IR/old_pc and PC load strobes, PC source
//   reg_write, wb_sel            : rd write strobe and writeback source
//   retire          : pulse on the last cycle of each instruction
//   illegal         : high while trapped
//   state_dbg       : current state encoding
module multicycle_ctrl
  import alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              instr,
  multicycle_ctrl_if.master        mem,
  input  logic                     zero,
  input  logic                     lt,
  input  logic                     ltu,
  output alu_op_t                  alu_op,
  output logic [1:0]               src_a_sel,
  output logic [1:0]               src_b_sel,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic [1:0]               pc_src,
  output logic                     reg_write,
  output logic [1:0]               wb_sel,
  output logic                     retire,
  output logic                     illegal,
  output logic [2:0]               state_dbg
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_MEM_WB, S_ALU_WB, S_LINK, S_TRAP
  } state_t;

  state_t state, state_nxt;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       known_opc, op_legal, br_legal, br_taken;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // Register/immediate fields belong to the datapath.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Shared OP / OP-IMM mapping; alt selects SUB/SRA.
  function automatic alu_op_t arith_op(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: known_opc = 1'b1;
      default:                               known_opc = 1'b0;
    endcase
  end

  // funct7=0x20 only qualifies ADD->SUB and SRL->SRA.
  assign op_legal = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101));
  assign br_legal = (f3[2:1] != 2'b01);

  always_comb begin
    case (f3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    alu_op       = ALU_ADD;
    src_a_sel    = 2'd0;
    src_b_sel    = 2'd0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    illegal      = 1'b0;
    state_dbg    = state;
    unique case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        src_a_sel   = 2'd1;
        src_b_sel   = 2'd2;
        if (mem.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // alu_out latches old_pc+imm: the branch/JAL target.
        src_a_sel = 2'd2;
        src_b_sel = 2'd1;
        state_nxt = known_opc ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        case (opcode)
          OPC_OP: begin
            alu_op    = arith_op(f3, f7 == 7'h20);
            state_nxt = op_legal ? S_ALU_WB : S_TRAP;
          end
          OPC_OPIMM: begin
            src_b_sel = 2'd1;
            alu_op    = arith_op(f3, (f3 == 3'b101) && f7[5]);
            state_nxt = S_ALU_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            src_b_sel = 2'd1;
            state_nxt = S_MEM;
          end
          OPC_BRANCH: begin
            alu_op = ALU_SUB;
            if (br_legal) begin
              retire    = 1'b1;
              state_nxt = S_FETCH;
              if (br_taken) begin
                pc_write = 1'b1;
                pc_src   = 2'd1;
              end
            end else begin
              state_nxt = S_TRAP;
            end
          end
          OPC_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 2'd1;
            state_nxt = S_LINK;
          end
          OPC_JALR: begin
            src_b_sel = 2'd1;
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            state_nxt = S_LINK;
          end
          OPC_LUI: begin
            src_b_sel = 2'd1;
            alu_op    = ALU_COPY_B;
            state_nxt = S_ALU_WB;
          end
          OPC_AUIPC: begin
            src_a_sel = 2'd2;
            src_b_sel = 2'd1;
            state_nxt = S_ALU_WB;
          end
          default: state_nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = (opcode == OPC_STORE);
        if (mem.mem_ready) begin
          if (opcode == OPC_STORE) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_MEM_WB;
          end
        end
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_LINK: begin
        src_a_sel = 2'd2;
        src_b_sel = 2'd2;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
    endcase
    // Reset is synchronous for the state, but outputs must go quiet at once
    // so an in-flight memory request is dropped in the reset cycle itself.
    if (!rst_n) begin
      alu_op       = ALU_ADD;
      src_a_sel    = 2'd0;
      src_b_sel    = 2'd0;
      mem.mem_req  = 1'b0;
      mem.mem_we   = 1'b0;
      mem.addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      reg_write    = 1'b0;
      wb_sel       = 2'd0;
      retire       = 1'b0;
      illegal      = 1'b0;
      state_dbg    = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  alu_op_t     alu_op;
  logic [1:0]  src_a_sel, src_b_sel, pc_src, wb_sel;
  logic        ir_write, pc_write, reg_write, retire, illegal;
  logic [2:0]  state_dbg;

  multicycle_ctrl_if mif();

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem(mif),
    .zero(zero), .lt(lt), .ltu(ltu),
    .alu_op(alu_op), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // One expected cycle of controller behaviour.
  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire, illegal;
    alu_op_t    alu;
    logic [1:0] sa, sb;
  } exp_t;

  typedef struct packed { logic ready, zero, lt, ltu; } drv_t;

  exp_t q_e[$];
  drv_t q_d[$];
  int   n_chk = 0, n_fail = 0;

  function automatic exp_t idle(input logic [2:0] st);
    exp_t r;
    r = '0;
    r.st = st;
    r.alu = ALU_ADD;
    return r;
  endfunction

  function automatic drv_t rnd_drv();
    drv_t d;
    d = 4'($urandom);
    return d;
  endfunction

  function automatic alu_op_t arith(input logic [2:0] f3, input logic alt);
    alu_op_t base [8];
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (alt && f3 == 3'd0) return ALU_SUB;
    if (alt && f3 == 3'd5) return ALU_SRA;
    return base[f3];
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input drv_t d);
    case (f3)
      3'd0: return d.zero;   // beq
      3'd1: return !d.zero;  // bne
      3'd4: return d.lt;     // blt
      3'd5: return !d.lt;    // bge
      3'd6: return d.ltu;    // bltu
      3'd7: return !d.ltu;   // bgeu
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.st = state_dbg;       o.mem_req = mif.mem_req;  o.mem_we = mif.mem_we;
    o.addr_sel = mif.addr_sel; o.ir_write = ir_write; o.pc_write = pc_write;
    o.pc_src = pc_src;      o.reg_write = reg_write;  o.wb_sel = wb_sel;
    o.retire = retire;      o.illegal = illegal;      o.alu = alu_op;
    o.sa = src_a_sel;       o.sb = src_b_sel;
    return o;
  endfunction

  task automatic chk(input string tag, input exp_t o, input exp_t e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input exp_t e, input drv_t d);
    q_e.push_back(e);
    q_d.push_back(d);
  endtask

  // Builds the expected cycle trace for one instruction from the ISA rules:
  // w fetch wait cycles, m memory wait cycles; xf optionally pins the flags
  // seen in EXECUTE.
  task automatic build(input logic [31:0] ins, input int w, input int m,
                       input logic use_xf, input drv_t xf, output logic trapped);
    exp_t e; drv_t d;
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
    int tail; // 0 done, 1 ALU_WB, 2 LINK, 3 MEM, 4 TRAP
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    tail = 0;
    for (int i = 0; i < w; i++) begin
      e = idle(3'd0); e.mem_req = 1; e.sa = 2'd1; e.sb = 2'd2;
      d = rnd_drv(); d.ready = 0; push(e, d);
    end
    e = idle(3'd0); e.mem_req = 1; e.sa = 2'd1; e.sb = 2'd2;
    e.ir_write = 1; e.pc_write = 1;
    d = rnd_drv(); d.ready = 1; push(e, d);
    e = idle(3'd1); e.sa = 2'd2; e.sb = 2'd1; push(e, rnd_drv());
    e = idle(3'd2); d = use_xf ? xf : rnd_drv();
    case (opc)
      7'b0110011: begin
        e.alu = arith(f3, f7 == 7'h20);
        tail = (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? 1 : 4;
      end
      7'b0010011: begin e.sb = 2'd1; e.alu = arith(f3, f3 == 3'd5 && ins[30]); tail = 1; end
      7'b0000011, 7'b0100011: begin e.sb = 2'd1; tail = 3; end
      7'b1100011: begin
        e.alu = ALU_SUB;
        if (f3 == 3'd2 || f3 == 3'd3) tail = 4;
        else begin
          e.retire = 1;
          if (br_cond(f3, d)) begin e.pc_write = 1; e.pc_src = 2'd1; end
        end
      end
      7'b1101111: begin e.pc_write = 1; e.pc_src = 2'd1; tail = 2; end
      7'b1100111: begin e.sb = 2'd1; e.pc_write = 1; e.pc_src = 2'd2; tail = 2; end
      7'b0110111: begin e.sb = 2'd1; e.alu = ALU_COPY_B; tail = 1; end
      7'b0010111: begin e.sa = 2'd2; e.sb = 2'd1; tail = 1; end
      default: tail = 5; // unknown opcode: no EXECUTE cycle
    endcase
    if (tail != 5) push(e, d);
    case (tail)
      1: begin e = idle(3'd5); e.reg_write = 1; e.retire = 1; push(e, rnd_drv()); end
      2: begin
        e = idle(3'd6); e.sa = 2'd2; e.sb = 2'd2; e.reg_write = 1; e.wb_sel = 2'd2;
        e.retire = 1; push(e, rnd_drv());
      end
      3: begin
        for (int i = 0; i <= m; i++) begin
          e = idle(3'd3); e.mem_req = 1; e.addr_sel = 1; e.mem_we = (opc == 7'b0100011);
          d = rnd_drv(); d.ready = (i == m);
          if (i == m && opc == 7'b0100011) e.retire = 1;
          push(e, d);
        end
        if (opc == 7'b0000011) begin
          e = idle(3'd4); e.reg_write = 1; e.wb_sel = 2'd1; e.retire = 1; push(e, rnd_drv());
        end
      end
      default: ;
    endcase
    trapped = (tail >= 4);
    if (trapped)
      for (int i = 0; i < 3; i++) begin
        e = idle(3'd7); e.illegal = 1; push(e, rnd_drv());
      end
  endtask

  // Plays the queued trace (first 'limit' cycles if limit >= 0).
  task automatic run(input string tag, input logic [31:0] ins, input int limit);
    int n;
    drv_t d;
    n = q_e.size();
    if (limit >= 0 && limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) instr = ins;
      d = q_d[i];
      mif.mem_ready = d.ready; zero = d.zero; lt = d.lt; ltu = d.ltu;
      #1;
      chk($sformatf("%s_c%0d", tag, i), observe(), q_e[i]);
    end
    q_e.delete();
    q_d.delete();
  endtask

  // n cycles of reset with mem_ready high, then the release cycle.
  task automatic do_reset(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 0; mif.mem_ready = 1;
      {zero, lt, ltu} = 3'($urandom);
      #1;
      chk($sformatf("%s_rst%0d", tag, i), observe(), idle(3'd0));
    end
    @(negedge clk);
    rst_n = 1; mif.mem_ready = 0;
    #1;
    e = idle(3'd0); e.mem_req = 1; e.sa = 2'd1; e.sb = 2'd2;
    chk($sformatf("%s_release", tag), observe(), e);
  endtask

  task automatic dir(input string tag, input logic [31:0] ins, input int w, input int m,
                     input logic use_xf, input drv_t xf);
    logic tr;
    build(ins, w, m, use_xf, xf, tr);
    run(tag, ins, -1);
    if (tr) do_reset({tag, "_rec"}, 2);
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: begin
        r[6:0] = 7'b0110011;
        if ($urandom_range(0, 3) == 0) r[31:25] = 7'($urandom);
        else r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b1101111;
      6: r[6:0] = 7'b1100111;
      7: r[6:0] = 7'b0110111;
      8: r[6:0] = 7'b0010111;
      9: r[6:0] = 7'h7F;
      default: r[6:0] = 7'b0001111;
    endcase
    return r;
  endfunction

  initial begin
    logic tr;
    logic [31:0] ins;
    mif.mem_ready = 1'b1;
    do_reset("init", 3);

    dir("add",   32'h002081B3, 0, 0, 1'b0, 4'b0000);
    dir("sub",   32'h402081B3, 0, 0, 1'b0, 4'b0000);
    dir("srai",  32'h4020D193, 0, 0, 1'b0, 4'b0000);
    dir("beq_t", 32'h00208463, 0, 0, 1'b1, 4'b0100);
    dir("beq_n", 32'h00208463, 1, 0, 1'b1, 4'b0000);
    dir("bgeu",  32'h0020F463, 0, 0, 1'b1, 4'b0001);
    dir("lw",    32'h0000A183, 0, 2, 1'b0, 4'b0000);
    dir("sw",    32'h0030A023, 2, 1, 1'b0, 4'b0000);
    dir("jalr",  32'h000080E7, 0, 0, 1'b0, 4'b0000);
    dir("jal",   32'h008000EF, 1, 0, 1'b0, 4'b0000);
    dir("lui",   32'h123451B7, 0, 0, 1'b0, 4'b0000);
    dir("auipc", 32'h00001197, 0, 0, 1'b0, 4'b0000);
    dir("bad7f", 32'h0000007F, 0, 0, 1'b0, 4'b0000);
    dir("r_f7",  32'h022081B3, 0, 0, 1'b0, 4'b0000);
    dir("br010", 32'h0020A463, 0, 0, 1'b0, 4'b0000);

    // Reset pulse in the middle of a load's memory wait.
    build(32'h0000A183, 0, 2, 1'b0, 4'b0000, tr);
    run("lw_abort", 32'h0000A183, 4);
    do_reset("mid_mem", 1);
    dir("after_abort", 32'h002081B3, 0, 0, 1'b0, 4'b0000);

    for (int k = 0; k < 60; k++) begin
      ins = rnd_ins();
      dir($sformatf("rnd%0d_%h", k, ins), ins, $urandom_range(0, 2), $urandom_range(0, 2),
          1'b0, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
